// File: rtl/nodemerge_n.sv
// Token-steered N-way flit merge into an OUT_DEPTH-entry output FIFO.
// Optional bad-token counter port enabled by NODEMERGE_BADSEL_CNT_EN.
module nodemerge_n #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 11,
  parameter int SEL_W     = 3,
  parameter int OUT_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     _RESET,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel_data,
  input  logic                     sel_valid,
  output logic                     sel_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
`ifdef NODEMERGE_BADSEL_CNT_EN
  ,
  output logic [7:0]               bad_sel_cnt
`endif
);

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W + 1)'(NUM_IN);
  localparam logic [CNT_W-1:0] DEPTH_L  = CNT_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0] LAST_L   = PTR_W'(OUT_DEPTH - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              wait_st, full, push, pop;
  logic              sel_ok, sel_hs, dvalid;
  logic [NUM_IN-1:0] sel_oh;
  logic [DATA_W-1:0] dsel;

  always_comb begin
    sel_oh = '0;
    dsel   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_oh[i] = (sel_q == SEL_W'(i));
      dsel = dsel | (in_data[i*DATA_W +: DATA_W] & {DATA_W{sel_oh[i]}});
    end
    dvalid = |(in_valid & sel_oh);
  end

  // ready is a function of the registered count only
  assign wait_st   = (state_q == WAIT_DATA);
  assign full      = (cnt_q == DEPTH_L);
  assign in_ready  = (wait_st && !full) ? sel_oh : '0;
  assign push      = wait_st && dvalid && !full;
  assign sel_ready = !wait_st || push;
  assign sel_ok    = ({1'b0, sel_data} < NUM_IN_L);
  assign sel_hs    = sel_valid && sel_ready;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_q[rd_q] : '0;
  assign busy      = wait_st || out_valid;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE, WAIT_DATA: begin
        if (sel_ready) begin
          state_d = IDLE;
          if (sel_hs && sel_ok) begin
            state_d = WAIT_DATA;
            sel_d   = sel_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge _RESET) begin
    if (!_RESET) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge clk or negedge _RESET) begin
    if (!_RESET) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= dsel;
        wr_q <= (wr_q == LAST_L) ? '0 : wr_q + 1'b1;
      end
      if (pop) rd_q <= (rd_q == LAST_L) ? '0 : rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef NODEMERGE_BADSEL_CNT_EN
  logic [7:0] bad_q;

  always_ff @(posedge clk or negedge _RESET) begin
    if (!_RESET) bad_q <= '0;
    else if (sel_hs && !sel_ok && bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
  end

  assign bad_sel_cnt = bad_q;
`endif

endmodule

// File: tb/tb_nodemerge_n.sv
// Bench for nodemerge_n: default 4-way instance plus an 8-way/32-bit/depth-3 instance.
module tb_nodemerge_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [43:0]  in_data4;
  logic [3:0]   in_valid4, in_ready4;
  logic [2:0]   sel4;
  logic         sel_valid4, sel_ready4;
  logic [10:0]  out_data4;
  logic         out_valid4, out_ready4, busy4;

  logic [255:0] in_data8;
  logic [7:0]   in_valid8, in_ready8;
  logic [2:0]   sel8;
  logic         sel_valid8, sel_ready8;
  logic [31:0]  out_data8;
  logic         out_valid8, out_ready8, busy8;
`ifdef NODEMERGE_BADSEL_CNT_EN
  logic [7:0]   bad4, bad8;
`endif

  nodemerge_n u_dut4 (
    .clk(clk), ._RESET(rst_n),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .sel_data(sel4), .sel_valid(sel_valid4), .sel_ready(sel_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .busy(busy4)
`ifdef NODEMERGE_BADSEL_CNT_EN
    , .bad_sel_cnt(bad4)
`endif
  );

  nodemerge_n #(.NUM_IN(8), .DATA_W(32), .SEL_W(3), .OUT_DEPTH(3)) u_dut8 (
    .clk(clk), ._RESET(rst_n),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .sel_data(sel8), .sel_valid(sel_valid8), .sel_ready(sel_ready8),
    .out_data(out_data8), .out_valid(out_valid8), .out_ready(out_ready8),
    .busy(busy8)
`ifdef NODEMERGE_BADSEL_CNT_EN
    , .bad_sel_cnt(bad8)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] f8(input int i, input int k);
    return 32'hA000_0000 | (32'(i) << 16) | 32'(k & 16'hFFFF);
  endfunction

  typedef struct {
    logic [2:0]  tok;
    logic        good;
    logic [10:0] exp;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] expq[$];
  int          popcyc[$];
  int          issued[8];
  int          taken[8];

  initial begin
    int idx, cyc;
    logic prev_bad, sel_acc;

    tbl[0] = '{3'd0, 1'b1, 11'h101};
    tbl[1] = '{3'd1, 1'b1, 11'h202};
    tbl[2] = '{3'd2, 1'b1, 11'h303};
    tbl[3] = '{3'd3, 1'b1, 11'h404};
    tbl[4] = '{3'd5, 1'b0, 11'h000};
    tbl[5] = '{3'd2, 1'b1, 11'h303};

    rst_n = 1'b1;
    in_data4 = '0; in_valid4 = '0; sel4 = '0; sel_valid4 = 1'b0; out_ready4 = 1'b0;
    in_data8 = '0; in_valid8 = '0; sel8 = '0; sel_valid8 = 1'b0; out_ready8 = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", out_valid4, 0);
    chk("rst out_data", out_data4, 0);
    chk("rst in_ready", in_ready4, 0);
    chk("rst sel_ready", sel_ready4, 1);
    chk("rst busy", busy4, 0);
`ifdef NODEMERGE_BADSEL_CNT_EN
    chk("rst bad_sel_cnt", bad4, 0);
`endif
    rst_n = 1'b1;

    // token table streamed back to back, all inputs valid
    in_data4 = {11'h404, 11'h303, 11'h202, 11'h101};
    in_valid4 = 4'hF;
    out_ready4 = 1'b1;
    idx = 0; cyc = 0; prev_bad = 1'b0;
    while ((idx < 6 || expq.size() > 0) && cyc < 60) begin
      @(negedge clk);
      sel_valid4 = (idx < 6);
      if (idx < 6) sel4 = tbl[idx].tok;
      #1;
      if (prev_bad) chk("no in_ready after bad tok", in_ready4, 0);
      prev_bad = 1'b0;
      if (sel_valid4 && sel_ready4) begin
        if (tbl[idx].good) expq.push_back(32'(tbl[idx].exp));
        else prev_bad = 1'b1;
        idx++;
      end
      if (out_valid4 && out_ready4) begin
        if (expq.size() == 0) chk("tbl unexpected out", out_valid4, 0);
        else chk("tbl out_data", out_data4, expq.pop_front());
        popcyc.push_back(cyc);
      end
      cyc++;
    end
    sel_valid4 = 1'b0;
    chk("tbl all tokens", idx, 6);
    chk("tbl drained", expq.size(), 0);
    if (popcyc.size() < 4) chk("tbl pop count", popcyc.size(), 5);
    else begin
      chk("tbl first latency", popcyc[0], 2);
      for (int j = 1; j < 4; j++) chk("tbl consecutive", popcyc[j], popcyc[0] + j);
    end
`ifdef NODEMERGE_BADSEL_CNT_EN
    chk("bad_sel_cnt one", bad4, 1);
`endif

    // token 3 with all inputs valid
    @(negedge clk);
    sel4 = 3'd3; sel_valid4 = 1'b1;
    #1 chk("tok3 sel_ready", sel_ready4, 1);
    @(negedge clk);
    sel_valid4 = 1'b0;
    #1 chk("only ch3 ready", in_ready4, 4'b1000);
    @(negedge clk);
    #1;
    chk("tok3 out_valid", out_valid4, 1);
    chk("tok3 out_data", out_data4, 11'h404);
    chk("tok3 idle ready", in_ready4, 0);

    // lone out-of-range token
    @(negedge clk);
    sel4 = 3'd5; sel_valid4 = 1'b1;
    #1;
    chk("bad tok sel_ready", sel_ready4, 1);
    chk("bad tok in_ready", in_ready4, 0);
    @(negedge clk);
    sel_valid4 = 1'b0;
    #1;
    chk("bad tok dropped rdy", in_ready4, 0);
    chk("bad tok not busy", busy4, 0);
`ifdef NODEMERGE_BADSEL_CNT_EN
    chk("bad_sel_cnt two", bad4, 2);
`endif

    // backpressure: three tokens to input 1, FIFO depth 2
    out_ready4 = 1'b0;
    in_valid4 = 4'b0010;
    @(negedge clk);
    sel4 = 3'd1; sel_valid4 = 1'b1;
    #1 chk("bp tok1", sel_ready4, 1);
    @(negedge clk);
    in_data4[11 +: 11] = 11'h211;
    #1 chk("bp rdy flit1", in_ready4, 4'b0010);
    @(negedge clk);
    in_data4[11 +: 11] = 11'h212;
    #1 chk("bp rdy flit2", in_ready4, 4'b0010);
    @(negedge clk);
    sel_valid4 = 1'b0;
    in_data4[11 +: 11] = 11'h213;
    #1;
    chk("bp full blocks", in_ready4, 0);
    chk("bp full sel_ready", sel_ready4, 0);
    @(negedge clk);
    out_ready4 = 1'b1;
    #1;
    chk("bp pop no ready", in_ready4, 0);
    chk("bp head", out_data4, 11'h211);
    @(negedge clk);
    out_ready4 = 1'b0;
    #1 chk("bp ready after pop", in_ready4, 4'b0010);
    @(negedge clk);
    in_valid4 = 4'b0000;
    out_ready4 = 1'b1;
    #1 chk("bp out2", out_data4, 11'h212);
    @(negedge clk);
    #1 chk("bp out3", out_data4, 11'h213);
    @(negedge clk);
    #1;
    chk("bp empty", out_valid4, 0);
    chk("bp idle", busy4, 0);

    // async reset in WAIT_DATA with one flit held
    out_ready4 = 1'b0;
    in_valid4 = 4'b0001;
    in_data4[0 +: 11] = 11'h101;
    @(negedge clk);
    sel4 = 3'd0; sel_valid4 = 1'b1;
    @(negedge clk);
    sel4 = 3'd1;
    #1 chk("rstw rdy0", in_ready4, 4'b0001);
    @(negedge clk);
    sel_valid4 = 1'b0;
    #1;
    chk("rstw busy", busy4, 1);
    chk("rstw out_valid", out_valid4, 1);
    chk("rstw waiting ch1", in_ready4, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw async out_valid", out_valid4, 0);
    chk("rstw async sel_ready", sel_ready4, 1);
    chk("rstw async in_ready", in_ready4, 0);
    chk("rstw async out_data", out_data4, 0);
    chk("rstw async busy", busy4, 0);
`ifdef NODEMERGE_BADSEL_CNT_EN
    chk("rstw bad_sel_cnt", bad4, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    in_valid4 = '0;

    // 8-way random tokens, data valid and backpressure
    expq.delete();
    sel_acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (sel_acc) sel_valid8 = 1'b0;
      sel_acc = 1'b0;
      if (!sel_valid8 && c < 2500 && $urandom_range(0, 3) != 0) begin
        sel8 = 3'($urandom_range(0, 7));
        sel_valid8 = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
        in_valid8[i] = ($urandom_range(0, 3) != 0);
        in_data8[i*32 +: 32] = f8(i, taken[i]);
      end
      out_ready8 = (c >= 2500) ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      if ($countones(in_ready8) > 1) chk("rnd in_ready onehot", in_ready8, 0);
      if (sel_valid8 && sel_ready8) begin
        expq.push_back(f8(int'(sel8), issued[sel8]));
        issued[sel8]++;
        sel_acc = 1'b1;
      end
      for (int i = 0; i < 8; i++)
        if (in_valid8[i] && in_ready8[i]) taken[i]++;
      if (out_valid8 && out_ready8) begin
        if (expq.size() == 0) chk("rnd unexpected out", out_valid8, 0);
        else chk("rnd out_data", out_data8, expq.pop_front());
      end
    end
    chk("rnd drained", expq.size(), 0);
    chk("rnd final out_valid", out_valid8, 0);
    for (int i = 0; i < 8; i++) chk("rnd taken vs issued", taken[i], issued[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nodemerge_n.md
# nodemerge_n

Parametrised, clocked successor of the four-way node merge in the router output path. A select token on the control channel names one of `NUM_IN` input channels; exactly one flit is taken from that input and forwarded through an `OUT_DEPTH`-entry output FIFO. Select tokens that name no existing input are dropped and do not stall the merge. Sits between the per-direction input buffers and the link driver of each NoC node.

## Interface
- `NUM_IN`, 4: number of data input channels, 2..16.
- `DATA_W`, 11: flit width in bits.
- `SEL_W`, 3: select token width; must be ≥ ceil(log2(`NUM_IN`)).
- `OUT_DEPTH`, 2: output FIFO entries, 1..16; any value, not only powers of two.
- `clk` in 1: single clock; every register is rising-edge.
- `_RESET` in 1: asynchronous, active-low reset.
- `in_data` in `NUM_IN*DATA_W`: input flits; channel i occupies bits [i*DATA_W +: DATA_W].
- `in_valid` in `NUM_IN`: per-channel valid.
- `in_ready` out `NUM_IN`: per-channel ready; at most one bit high at a time.
- `sel_data` in `SEL_W`: select token.
- `sel_valid` in 1: select token valid.
- `sel_ready` out 1: select token accepted.
- `out_data` out `DATA_W`: head of the output FIFO.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: downstream accepts the head.
- `busy` out 1: high in WAIT_DATA or while the FIFO is non-empty.
- `bad_sel_cnt` out 8: present only with `NODEMERGE_BADSEL_CNT_EN` (see Configuration).

## Operation
- A transfer completes on any rising edge where valid and ready are both high; the same rule applies to all three channel types.
- FSM with two states, IDLE and WAIT_DATA, plus a `sel_q` register.
- IDLE: `sel_ready`=1 and all `in_ready`=0.
  - Token with `sel_data` < `NUM_IN`: `sel_q`←`sel_data`, next state WAIT_DATA.
  - Token with `sel_data` ≥ `NUM_IN`: the token is consumed and discarded; state stays IDLE.
- WAIT_DATA: `in_ready[sel_q]` = FIFO not full; all other `in_ready` bits are 0.
  - On the data handshake the flit is pushed into the FIFO.
  - `sel_ready` = data handshake this cycle. Under this rule a new token is accepted in the same cycle the current flit completes, using the IDLE rules above. Next state is WAIT_DATA for a valid token, otherwise IDLE.
  - `in_valid` on unselected channels is ignored. Those flits are held upstream and never reordered.
- Output FIFO: circular buffer with read and write pointers that wrap from `OUT_DEPTH`-1 to 0, plus an occupancy count of width clog2(`OUT_DEPTH`+1).
  - Push and pop in the same cycle leave the count unchanged.
  - When the FIFO is full, a pop does not raise `in_ready` in that same cycle. Ready depends on the registered full flag only, so there is no ready path from `out_ready` to `in_ready`.
- Order is preserved: flits leave in the order their select tokens were accepted.

## Timing
- Reset values: state IDLE; `sel_q`=0; FIFO empty; `out_valid`=0; `out_data`=0; `in_ready`=0; `sel_ready`=1; `busy`=0; `bad_sel_cnt`=0.
- Reset is asynchronous and may assert mid-operation. Any captured selection and all FIFO contents are discarded, with no partial output.
- Latency:
  - Token accepted at edge 0, data is ready from cycle 1.
  - Flit accepted at edge k, `out_valid` is high after edge k (registered FIFO, one-cycle latency).
- Sustained throughput is one flit per cycle when tokens, data and `out_ready` are continuously available.
- `OUT_DEPTH`=1 with `out_ready` held high gives one flit every two cycles.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `NODEMERGE_BADSEL_CNT_EN` defined: the `bad_sel_cnt` port exists.
  - 8-bit counter, incremented on each discarded out-of-range token.
  - Saturates at 255 and clears only on reset.
- `NODEMERGE_BADSEL_CNT_EN` undefined: no port and no counter logic. Out-of-range tokens are still silently discarded.

## Test plan
- Defaults; tokens 0,1,2,3, each input holding a distinct flit (0x101, 0x202, 0x303, 0x404), `out_ready`=1 → out sequence 0x101, 0x202, 0x303, 0x404 on four consecutive cycles after the first latency.
- Token 5 then token 2 → token 5 is consumed with no `in_ready` pulse; 0x303 is forwarded; `bad_sel_cnt`=1 when the macro is enabled.
- `out_ready`=0 with `OUT_DEPTH`=2 and three tokens to input 1 → two flits accepted, then `in_ready[1]`=0. One pop → `in_ready[1]` rises the following cycle and the third flit is accepted.
- `in_valid` high on all inputs, token 3 pending → only `in_ready[3]`=1; inputs 0–2 are untouched.
- `_RESET` asserted low while in WAIT_DATA with 1 flit in the FIFO → `out_valid`=0, `sel_ready`=1 and `in_ready`=0 immediately, without waiting for a clock edge.
- `NUM_IN`=8, `SEL_W`=3, `DATA_W`=32, `OUT_DEPTH`=3; random tokens and backpressure checked against a scoreboard → order is preserved, FIFO pointers wrap correctly, nothing is lost or duplicated.
